// File: rtl/alu_issue.sv
// ALU issue stage: RV32I ALU decode into a registered valid/ready payload.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      operand1,
  output logic [31:0]      operand2,
  output logic [2:0]       opcode,
  output logic             is_signed,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  opc;
    logic        sgn;
    logic [4:0]  rd;
    logic        ill;
  } pay_t;

  localparam logic [6:0] MAJ_OP    = 7'b0110011;
  localparam logic [6:0] MAJ_OPIMM = 7'b0010011;
  localparam logic [6:0] MAJ_LUI   = 7'b0110111;
  localparam logic [6:0] MAJ_AUIPC = 7'b0010111;

  logic [6:0] maj;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       shift;
  pay_t       dec;
  pay_t       e0, e0_n;
  logic       v0, v0_n;
  logic       push, pop;

  assign maj   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec    = '0;
    dec.rd = instr[11:7];
    unique case (1'b1)
      (maj == MAJ_OP): begin
        dec.ill = !(f7 == 7'h00 || f7 == 7'h20) ||
                  (f7 == 7'h20 && !(f3 == 3'b000 || f3 == 3'b101));
        dec.op1 = rs1_data;
        dec.op2 = shift ? {27'b0, rs2_data[4:0]} : rs2_data;
        dec.opc = f3;
        dec.sgn = (f3 == 3'b000) ? !f7[5] :
                  (f3 == 3'b101) ?  f7[5] : 1'b0;
      end
      (maj == MAJ_OPIMM): begin
        dec.ill = (f3 == 3'b001 && f7 != 7'h00) ||
                  (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
        dec.op1 = rs1_data;
        dec.op2 = shift ? {27'b0, instr[24:20]}
                        : {{20{instr[31]}}, instr[31:20]};
        dec.opc = f3;
        dec.sgn = (f3 == 3'b000) ? 1'b1 :
                  (f3 == 3'b101) ? f7[5] : 1'b0;
      end
      (maj == MAJ_LUI): begin
        dec.op2 = {instr[31:12], 12'b0};
        dec.sgn = 1'b1;
      end
      (maj == MAJ_AUIPC): begin
        dec.op1 = pc;
        dec.op2 = {instr[31:12], 12'b0};
        dec.sgn = 1'b1;
      end
      default: dec.ill = 1'b1;
    endcase
    // illegal payloads still flow, but carry no operands
    if (dec.ill) begin
      dec.op1 = '0;
      dec.op2 = '0;
      dec.opc = '0;
      dec.sgn = 1'b0;
    end
  end

  assign push      = in_valid && in_ready;
  assign pop       = v0 && out_ready;
  assign out_valid = v0;
  assign operand1  = e0.op1;
  assign operand2  = e0.op2;
  assign opcode    = e0.opc;
  assign is_signed = e0.sgn;
  assign rd        = e0.rd;
  assign illegal   = e0.ill;

`ifdef ALU_ISSUE_SKID_EN
  pay_t e1, e1_n;
  logic v1, v1_n;
  logic rdy_q;

  assign in_ready = rdy_q;

  always_comb begin
    e0_n = e0;
    e1_n = e1;
    v0_n = v0;
    v1_n = v1;
    unique case (1'b1)
      (push && pop): begin
        if (v1) begin
          e0_n = e1;
          e1_n = dec;
        end else begin
          e0_n = dec;
        end
      end
      (pop && !push): begin
        e0_n = e1;
        v0_n = v1;
        v1_n = 1'b0;
      end
      (push && !pop): begin
        if (v0) begin
          e1_n = dec;
          v1_n = 1'b1;
        end else begin
          e0_n = dec;
          v0_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // v1 implies v0, so the buffer is full exactly when v1 is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1    <= '0;
      v1    <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      e1    <= e1_n;
      v1    <= v1_n;
      rdy_q <= !v1_n;
    end
  end
`else
  assign in_ready = !v0 || out_ready;

  always_comb begin
    e0_n = e0;
    v0_n = v0;
    if (push) begin
      e0_n = dec;
      v0_n = 1'b1;
    end else if (pop) begin
      v0_n = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0          <= '0;
      v0          <= 1'b0;
      issue_count <= '0;
    end else begin
      e0 <= e0_n;
      v0 <= v0_n;
      if (pop) issue_count <= issue_count + 1'b1;
    end
  end

endmodule
